// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the transmit egress state encoding.
// Imported by the GMII transmit framer and its CRC helper.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE     = 8'h55;
    localparam logic [7:0]  SFD          = 8'hD5;
    localparam int          PREAMBLE_LEN = 7;
    localparam int          IFG_LEN      = 12;
    localparam int          MIN_PAYLOAD  = 60;
    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } eg_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 next-state function, LSB of the byte first.
// Purely combinational so the receive path can reuse it.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0] ^ data[i])
                crc_out = (crc_out >> 1) ^ CRC_POLY;
            else
                crc_out = crc_out >> 1;
        end
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// Store-and-forward GMII transmit framer: buffers raw frames, then sends
// preamble, SFD, payload, zero pad, FCS and inter-frame gap.
module gmii_tx_framer
    import eth_pkg::*;
#(
    parameter int BUF_AW  = 11,
    parameter int LQ_AW   = 2,
    parameter int MAX_LEN = 1514
)
(
    input  logic        gmii_gtx_clk,
    input  logic        rst_n,
    input  logic        fifo_dv,
    input  logic [7:0]  fifo_din,
    output logic        gmii_en,
    output logic [7:0]  gmii_dout,
    output logic [15:0] drop_cnt,
    output logic        busy
);

    localparam logic [BUF_AW:0] BUF_SIZE = {1'b1, {BUF_AW{1'b0}}};
    localparam logic [LQ_AW:0]  LQ_SIZE  = {1'b1, {LQ_AW{1'b0}}};
    localparam logic [15:0] C_MAX_LEN  = 16'(MAX_LEN);
    localparam logic [15:0] C_MIN_PAY  = 16'(MIN_PAYLOAD);
    localparam logic [15:0] C_PAD_LAST = 16'(MIN_PAYLOAD - 1);
    localparam logic [15:0] C_PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] C_IFG_LAST = 16'(IFG_LEN - 1);
    localparam logic [15:0] C_FCS_LAST = 16'd3;

    logic [7:0]      r_mem [0:(1<<BUF_AW)-1];
    logic [7:0]      r_rdata;
    logic [BUF_AW:0] r_wr_ptr;
    logic [BUF_AW:0] r_commit_ptr;
    logic [BUF_AW:0] r_rd_ptr;
    logic [15:0]     r_len;
    logic            r_bad;
    logic            r_dv_q;
    logic [15:0]     r_drop;

    logic [15:0]     r_lq [0:(1<<LQ_AW)-1];
    logic [LQ_AW:0]  r_lq_wp;
    logic [LQ_AW:0]  r_lq_rp;

    eg_state_t       r_state;
    eg_state_t       w_state_nxt;
    logic [15:0]     r_cnt;
    logic [15:0]     w_cnt_nxt;
    logic [15:0]     r_flen;
    logic [15:0]     w_flen_nxt;
    logic [31:0]     r_crc;
    logic [31:0]     w_crc_nxt;
    logic [31:0]     w_crc_upd;
    logic [31:0]     w_fcs;
    logic [7:0]      w_crc_din;
    logic            r_en;
    logic            w_en_nxt;
    logic [7:0]      r_dout;
    logic [7:0]      w_dout_nxt;
    logic            w_pop;
    logic            w_rd_inc;

    logic            w_full;
    logic            w_wr_en;
    logic            w_commit;
    logic            w_push;
    logic            w_lq_empty;
    logic            w_lq_full;

    assign w_full     = (r_wr_ptr - r_rd_ptr) == BUF_SIZE;
    assign w_wr_en    = fifo_dv && !r_bad && !w_full
                        && (r_len != C_MAX_LEN);
    assign w_commit   = !fifo_dv && r_dv_q;
    assign w_lq_empty = r_lq_wp == r_lq_rp;
    assign w_lq_full  = (r_lq_wp - r_lq_rp) == LQ_SIZE;
    assign w_push     = w_commit && !r_bad && !w_lq_full;

    always_ff @(posedge gmii_gtx_clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr[BUF_AW-1:0]] <= fifo_din;
        r_rdata <= r_mem[r_rd_ptr[BUF_AW-1:0]];
    end

    always_ff @(posedge gmii_gtx_clk) begin
        if (w_push)
            r_lq[r_lq_wp[LQ_AW-1:0]] <= r_len;
    end

    // A bad frame keeps consuming bytes until its commit edge, then is rewound.
    always_ff @(posedge gmii_gtx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_len        <= '0;
            r_bad        <= 1'b0;
            r_dv_q       <= 1'b0;
            r_drop       <= '0;
            r_lq_wp      <= '0;
        end else begin
            r_dv_q <= fifo_dv;
            if (fifo_dv) begin
                if (w_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_len    <= r_len + 16'd1;
                end else begin
                    r_bad <= 1'b1;
                end
            end else if (w_commit) begin
                if (w_push) begin
                    r_lq_wp      <= r_lq_wp + 1'b1;
                    r_commit_ptr <= r_wr_ptr;
                end else begin
                    r_wr_ptr <= r_commit_ptr;
                    if (r_drop != 16'hFFFF)
                        r_drop <= r_drop + 16'd1;
                end
                r_len <= '0;
                r_bad <= 1'b0;
            end
        end
    end

    always_ff @(posedge gmii_gtx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_flen   <= '0;
            r_crc    <= CRC_INIT;
            r_en     <= 1'b0;
            r_dout   <= 8'h00;
            r_lq_rp  <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flen  <= w_flen_nxt;
            r_crc   <= w_crc_nxt;
            r_en    <= w_en_nxt;
            r_dout  <= w_dout_nxt;
            if (w_pop)
                r_lq_rp <= r_lq_rp + 1'b1;
            if (w_rd_inc)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // The last gap cycle pops directly so back-to-back frames see 12 idles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;
        w_flen_nxt  = r_flen;
        w_pop       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_lq_empty) begin
                    w_pop       = 1'b1;
                    w_flen_nxt  = r_lq[r_lq_rp[LQ_AW-1:0]];
                    w_state_nxt = ST_PRE;
                end
            end
            ST_PRE: begin
                if (r_cnt == C_PRE_LAST) begin
                    w_state_nxt = ST_SFD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SFD: begin
                w_state_nxt = ST_DATA;
                w_cnt_nxt   = '0;
            end
            ST_DATA: begin
                if (r_cnt == r_flen - 16'd1) begin
                    if (r_flen < C_MIN_PAY) begin
                        w_state_nxt = ST_PAD;
                    end else begin
                        w_state_nxt = ST_FCS;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            ST_PAD: begin
                if (r_cnt == C_PAD_LAST) begin
                    w_state_nxt = ST_FCS;
                    w_cnt_nxt   = '0;
                end
            end
            ST_FCS: begin
                if (r_cnt == C_FCS_LAST) begin
                    w_state_nxt = ST_IFG;
                    w_cnt_nxt   = '0;
                end
            end
            ST_IFG: begin
                if (r_cnt == C_IFG_LAST) begin
                    w_cnt_nxt = '0;
                    if (!w_lq_empty) begin
                        w_pop       = 1'b1;
                        w_flen_nxt  = r_lq[r_lq_rp[LQ_AW-1:0]];
                        w_state_nxt = ST_PRE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_fcs     = ~r_crc;
    assign w_crc_din = (w_state_nxt == ST_DATA) ? r_rdata : 8'h00;

    crc32_d8 u_crc (
        .crc_in  (r_crc),
        .data    (w_crc_din),
        .crc_out (w_crc_upd)
    );

    // Reads run one byte ahead of the wire, starting as SFD is loaded.
    always_comb begin
        w_en_nxt   = 1'b0;
        w_dout_nxt = 8'h00;
        w_crc_nxt  = r_crc;
        w_rd_inc   = 1'b0;
        unique case (w_state_nxt)
            ST_PRE: begin
                w_en_nxt   = 1'b1;
                w_dout_nxt = PREAMBLE;
            end
            ST_SFD: begin
                w_en_nxt   = 1'b1;
                w_dout_nxt = SFD;
                w_crc_nxt  = CRC_INIT;
                w_rd_inc   = 1'b1;
            end
            ST_DATA: begin
                w_en_nxt   = 1'b1;
                w_dout_nxt = r_rdata;
                w_crc_nxt  = w_crc_upd;
                w_rd_inc   = w_cnt_nxt < (w_flen_nxt - 16'd1);
            end
            ST_PAD: begin
                w_en_nxt  = 1'b1;
                w_crc_nxt = w_crc_upd;
            end
            ST_FCS: begin
                w_en_nxt   = 1'b1;
                w_dout_nxt = w_fcs[{w_cnt_nxt[1:0], 3'b000} +: 8];
            end
            default: begin
                w_en_nxt = 1'b0;
            end
        endcase
    end

    assign gmii_en   = r_en;
    assign gmii_dout = r_dout;
    assign drop_cnt  = r_drop;
    assign busy      = !w_lq_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: framing, padding, FCS, gap, drops
// and asynchronous reset mid-frame.
module tb_gmii_tx_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dv_a, dv_b;
    logic [7:0]  din_a, din_b;
    logic        en_a, en_b;
    logic [7:0]  dout_a, dout_b;
    logic [15:0] drop_a, drop_b;
    logic        busy_a, busy_b;

    always #4 clk = ~clk;

    gmii_tx_framer dut_a (
        .gmii_gtx_clk (clk),
        .rst_n        (rst_n),
        .fifo_dv      (dv_a),
        .fifo_din     (din_a),
        .gmii_en      (en_a),
        .gmii_dout    (dout_a),
        .drop_cnt     (drop_a),
        .busy         (busy_a)
    );

    gmii_tx_framer #(.BUF_AW(6)) dut_b (
        .gmii_gtx_clk (clk),
        .rst_n        (rst_n),
        .fifo_dv      (dv_b),
        .fifo_din     (din_b),
        .gmii_en      (en_b),
        .gmii_dout    (dout_b),
        .drop_cnt     (drop_b),
        .busy         (busy_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int zerr = 0;

    logic [7:0] q_a[$], q_b[$], exp_q[$];
    int len_a[$], len_b[$];
    int start_a[$], start_b[$];
    int gap_a[$], gap_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : mon
        logic pa, pb;
        int ca, cb, la, lb;
        pa = 1'b0; pb = 1'b0;
        ca = 0; cb = 0; la = 0; lb = 0;
        forever begin
            @(negedge clk);
            if (en_a) begin
                if (!pa) begin
                    start_a.push_back(cyc);
                    gap_a.push_back(la);
                    ca = 0;
                end
                q_a.push_back(dout_a);
                ca++;
                la = 0;
            end else begin
                if (pa) len_a.push_back(ca);
                la++;
                if (dout_a !== 8'h00) zerr++;
            end
            pa = en_a;
            if (en_b) begin
                if (!pb) begin
                    start_b.push_back(cyc);
                    gap_b.push_back(lb);
                    cb = 0;
                end
                q_b.push_back(dout_b);
                cb++;
                lb = 0;
            end else begin
                if (pb) len_b.push_back(cb);
                lb++;
                if (dout_b !== 8'h00) zerr++;
            end
            pb = en_b;
        end
    end

    function automatic logic [31:0] crc_byte(logic [31:0] c, logic [7:0] d);
        for (int i = 0; i < 8; i++)
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    function automatic logic [7:0] pat(int kind, int i);
        case (kind)
            0: return 8'(i);
            1: return 8'(8'hA0 + i);
            2: return 8'(i * 3 + 1);
            default: return 8'(8'hFF - i);
        endcase
    endfunction

    function automatic int qget(int q[$], int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic logic [7:0] getb(bit w, int i);
        if (w) return (i < q_b.size()) ? q_b[i] : 8'hxx;
        return (i < q_a.size()) ? q_a[i] : 8'hxx;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_exp(int n, int kind);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(pat(kind, i));
    endtask

    task automatic send(bit w, int n, int kind, output int t_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (w) begin dv_b = 1'b1; din_b = pat(kind, i); end
            else   begin dv_a = 1'b1; din_a = pat(kind, i); end
        end
        @(posedge clk);
        #1 t_last = cyc;
        @(negedge clk);
        if (w) dv_b = 1'b0;
        else   dv_a = 1'b0;
    endtask

    task automatic wait_frames(bit w, int n, int budget, string tag);
        int k;
        k = 0;
        while (((w ? len_b.size() : len_a.size()) < n) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_arrive"}, 32'((w ? len_b.size() : len_a.size()) >= n), 1);
    endtask

    task automatic check_frame(bit w, int fidx, string tag);
        int off, flen, ln, tot, errs;
        logic [31:0] c, fcs, res;
        logic [7:0] e;
        ln = exp_q.size();
        tot = (ln < 60) ? 60 : ln;
        off = 0;
        for (int i = 0; i < fidx; i++)
            off += w ? qget(len_b, i) : qget(len_a, i);
        flen = w ? qget(len_b, fidx) : qget(len_a, fidx);
        chk({tag, "_len"}, flen, 8 + tot + 4);
        errs = 0;
        for (int i = 0; i < 7; i++)
            if (getb(w, off + i) !== 8'h55) errs++;
        if (getb(w, off + 7) !== 8'hD5) errs++;
        chk({tag, "_pre_errs"}, errs, 0);
        errs = 0;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < tot; i++) begin
            e = (i < ln) ? exp_q[i] : 8'h00;
            if (getb(w, off + 8 + i) !== e) errs++;
            c = crc_byte(c, e);
        end
        chk({tag, "_data_errs"}, errs, 0);
        fcs = {getb(w, off + 11 + tot), getb(w, off + 10 + tot),
               getb(w, off + 9 + tot), getb(w, off + 8 + tot)};
        chk({tag, "_fcs"}, fcs, ~c);
        res = 32'hFFFFFFFF;
        for (int i = 0; i < tot + 4; i++)
            res = crc_byte(res, getb(w, off + 8 + i));
        chk({tag, "_residue"}, res, 32'hDEBB20E3);
    endtask

    initial begin : stim
        int t, t1, base, k;
        rst_n = 1'b0;
        dv_a = 1'b0; dv_b = 1'b0;
        din_a = 8'h00; din_b = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_en", en_a, 0);
        chk("rst_dout", dout_a, 0);
        chk("rst_drop", drop_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_en_b", en_b, 0);
        chk("rst_busy_b", busy_b, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_en", en_a, 0);
        chk("idle_dout", dout_a, 0);
        chk("idle_busy", busy_a, 0);

        send(0, 64, 0, t);
        wait_frames(0, 1, 400, "f64");
        chk("f64_start", qget(start_a, 0), t + 2);
        fill_exp(64, 0);
        check_frame(0, 0, "f64");
        repeat (20) @(negedge clk);
        chk("f64_busy_done", busy_a, 0);

        send(0, 10, 1, t);
        wait_frames(0, 2, 400, "f10");
        chk("f10_start", qget(start_a, 1), t + 2);
        fill_exp(10, 1);
        check_frame(0, 1, "f10");
        repeat (30) @(negedge clk);

        send(0, 64, 2, t1);
        send(0, 64, 3, t);
        wait_frames(0, 4, 800, "b2b");
        chk("b2b_start", qget(start_a, 2), t1 + 2);
        chk("b2b_gap", qget(gap_a, 3), 12);
        fill_exp(64, 2);
        check_frame(0, 2, "b2b1");
        fill_exp(64, 3);
        check_frame(0, 3, "b2b2");
        chk("drop_a_zero", drop_a, 0);

        send(1, 100, 0, t1);
        send(1, 20, 1, t);
        wait_frames(1, 1, 400, "small");
        repeat (150) @(negedge clk);
        chk("small_drop_cnt", drop_b, 1);
        chk("small_frames", len_b.size(), 1);
        chk("small_start", qget(start_b, 0), t + 2);
        fill_exp(20, 1);
        check_frame(1, 0, "small");

        send(0, 64, 0, t);
        k = 0;
        while (!en_a && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("mid_rise", en_a, 1);
        repeat (20) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", en_a, 0);
        chk("mid_rst_dout", dout_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("trunc_len", 32'(qget(len_a, 4) < 76), 1);
        base = len_a.size();
        send(0, 64, 3, t);
        wait_frames(0, base + 1, 400, "post");
        chk("post_start", qget(start_a, base), t + 2);
        fill_exp(64, 3);
        check_frame(0, base, "post");
        chk("dout_zero_when_idle", zerr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
